// File: rtl/mc_control.sv
// Multi-cycle control FSM for a single-ALU MIPS datapath: fetch, decode, execute, memory, writeback.
// Latency: lw 5, sw 4, R/I-type 4, branch/jump 3, illegal 2 cycles, plus one cycle per memory wait.
// Backpressure: memory strobes are held until mem_ready is sampled; an optional wait limit aborts to FETCH.
module mc_control #(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic       mem_timeout,
  output logic       retire,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  logic [3:0] r_alu;
  logic       r_ok;
  logic [3:0] i_alu;
  logic       i_zext;
  logic       waiting;
  logic       timeout;

  // R-type funct to ALU op; r_ok flags functs this datapath supports
  always_comb begin
    r_ok  = 1'b1;
    r_alu = 4'd1;
    case (funct)
      6'h20:   r_alu = 4'd0;
      6'h21:   r_alu = 4'd1;
      6'h22:   r_alu = 4'd2;
      6'h23:   r_alu = 4'd3;
      6'h24:   r_alu = 4'd4;
      6'h25:   r_alu = 4'd5;
      6'h26:   r_alu = 4'd6;
      6'h2A:   r_alu = 4'd8;
      6'h2B:   r_alu = 4'd7;
      default: r_ok  = 1'b0;
    endcase
  end

  // Immediate-ALU opcode to ALU op; logical immediates are zero-extended
  always_comb begin
    i_alu = 4'd1;
    case (opcode)
      OP_ADDI:  i_alu = 4'd0;
      OP_ADDIU: i_alu = 4'd1;
      OP_SLTI:  i_alu = 4'd8;
      OP_SLTIU: i_alu = 4'd7;
      OP_ANDI:  i_alu = 4'd4;
      OP_ORI:   i_alu = 4'd5;
      OP_XORI:  i_alu = 4'd6;
      default:  i_alu = 4'd1;
    endcase
  end

  assign i_zext  = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // Limit reached: this cycle is spent aborting, so no access is requested in it
  assign timeout = (WAIT_LIMIT != 8'd0) && waiting && (wait_q == WAIT_LIMIT);

  // Output decode and next-state selection; reset forces strobes low and returns to FETCH
  always_comb begin
    alu_sel     = 4'd1;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    ext_zero    = 1'b0;
    pc_src      = 2'b00;
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    retire      = 1'b0;
    state_d     = state_q;

    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        if (timeout) begin
          mem_timeout = 1'b1;
          state_d     = S_FETCH;
        end else begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_en    = 1'b1;
            state_d  = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (r_ok) begin
              state_d = S_REXEC;
            end else begin
              illegal = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
          end
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
          OP_ANDI, OP_ORI, OP_XORI: state_d = S_IEXEC;
          OP_J: state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (timeout) begin
          mem_timeout = 1'b1;
          state_d     = S_FETCH;
        end else begin
          mem_read = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord = 1'b1;
        if (timeout) begin
          mem_timeout = 1'b1;
          state_d     = S_FETCH;
        end else begin
          mem_write = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_sel   = r_alu;
        state_d   = S_RWB;
      end
      S_RWB: begin
        alu_src_a = 1'b1;
        alu_sel   = r_alu;
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_sel   = 4'd2;
        pc_src    = 2'b01;
        pc_en     = (opcode == OP_BNE) ? ~zero : zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_sel   = i_alu;
        ext_zero  = i_zext;
        state_d   = S_IWB;
      end
      S_IWB: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_sel   = i_alu;
        ext_zero  = i_zext;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (rst) begin
      pc_en       = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      illegal     = 1'b0;
      mem_timeout = 1'b0;
      retire      = 1'b0;
      state_d     = S_FETCH;
    end
  end

  // Wait counter: counts unready cycles in a memory state, saturating, cleared on any state change or abort
  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) || timeout) begin
      wait_d = 8'd0;
    end else if (waiting && !mem_ready && (wait_q != 8'hFF)) begin
      wait_d = wait_q + 8'd1;
    end
  end

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic [3:0] alu_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic [1:0] pc_src;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
  logic       reg_dst, mem_to_reg, illegal, mem_timeout, retire;
  logic [3:0] state;

  int tests = 0;
  int failures = 0;

  mc_control #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .alu_sel(alu_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .pc_src(pc_src), .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .mem_timeout(mem_timeout), .retire(retire), .state(state)
  );

  always #5 clk = ~clk;

  // {state, pc_en, mem_read, mem_write, ir_write, reg_write, illegal, mem_timeout, retire}
  logic [11:0] ss;
  // {alu_sel, alu_src_a, alu_src_b, ext_zero, pc_src, iord, reg_dst, mem_to_reg}
  logic [13:0] dp;
  assign ss = {state, pc_en, mem_read, mem_write, ir_write, reg_write, illegal, mem_timeout, retire};
  assign dp = {alu_sel, alu_src_a, alu_src_b, ext_zero, pc_src, iord, reg_dst, mem_to_reg};

  localparam logic [13:0] DP_F   = {4'd1, 1'b0, 2'b01, 1'b0, 2'b00, 3'b000};
  localparam logic [13:0] DP_D   = {4'd1, 1'b0, 2'b11, 1'b0, 2'b00, 3'b000};
  localparam logic [13:0] DP_MA  = {4'd1, 1'b1, 2'b10, 1'b0, 2'b00, 3'b000};
  localparam logic [13:0] DP_MEM = {4'd1, 1'b0, 2'b00, 1'b0, 2'b00, 3'b100};
  localparam logic [13:0] DP_MWB = {4'd1, 1'b0, 2'b00, 1'b0, 2'b00, 3'b001};
  localparam logic [13:0] DP_J   = {4'd1, 1'b0, 2'b00, 1'b0, 2'b10, 3'b000};
  localparam logic [13:0] DP_BR  = {4'd2, 1'b1, 2'b00, 1'b0, 2'b01, 3'b000};
  localparam logic [13:0] DP_ORI = {4'd5, 1'b1, 2'b10, 1'b1, 2'b00, 3'b000};

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    #2;
    tests++;
    if (ss !== 12'h000) begin
      failures++;
      $display("FAIL reset_strobes: got %h want %h", ss, 12'h000);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (ss !== 12'h0D0) begin
      failures++;
      $display("FAIL reset_release_fetch: got %h want %h", ss, 12'h0D0);
    end
    mem_ready = 1'b0;
    next_cycle();
  endtask

  task automatic test_lw();
    logic [11:0] ess [5];
    logic [13:0] edp [5];
    ess = '{12'h0D0, 12'h100, 12'h200, 12'h340, 12'h409};
    edp = '{DP_F, DP_D, DP_MA, DP_MEM, DP_MWB};
    opcode = 6'b100011;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      tests++;
      if (ss !== ess[i]) begin
        failures++;
        $display("FAIL lw_c%0d state/strobes: got %h want %h", i, ss, ess[i]);
      end
      tests++;
      if (dp !== edp[i]) begin
        failures++;
        $display("FAIL lw_c%0d selects: got %h want %h", i, dp, edp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_rtype();
    logic [11:0] ess [4];
    logic [13:0] edp [4];
    logic [5:0]  fn  [2];
    logic [3:0]  alu [2];
    fn  = '{6'h2A, 6'h2B};
    alu = '{4'd8, 4'd7};
    ess = '{12'h0D0, 12'h100, 12'h600, 12'h709};
    opcode = 6'b000000;
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      funct = fn[k];
      edp = '{DP_F, DP_D, {alu[k], 1'b1, 2'b00, 1'b0, 2'b00, 3'b000},
              {alu[k], 1'b1, 2'b00, 1'b0, 2'b00, 3'b010}};
      for (int i = 0; i < 4; i++) begin
        #2;
        tests++;
        if (ss !== ess[i]) begin
          failures++;
          $display("FAIL rtype_f%h_c%0d state/strobes: got %h want %h", fn[k], i, ss, ess[i]);
        end
        tests++;
        if (dp !== edp[i]) begin
          failures++;
          $display("FAIL rtype_f%h_c%0d selects: got %h want %h", fn[k], i, dp, edp[i]);
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0]  op [3];
    logic        zr [3];
    logic [11:0] br [3];
    logic [11:0] ess [3];
    logic [13:0] edp [3];
    op = '{6'b000100, 6'b000101, 6'b000101};
    zr = '{1'b1, 1'b1, 1'b0};
    br = '{12'h881, 12'h801, 12'h881};
    edp = '{DP_F, DP_D, DP_BR};
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      opcode = op[k];
      zero = zr[k];
      ess = '{12'h0D0, 12'h100, br[k]};
      for (int i = 0; i < 3; i++) begin
        #2;
        tests++;
        if (ss !== ess[i]) begin
          failures++;
          $display("FAIL branch%0d_c%0d state/strobes: got %h want %h", k, i, ss, ess[i]);
        end
        tests++;
        if (dp !== edp[i]) begin
          failures++;
          $display("FAIL branch%0d_c%0d selects: got %h want %h", k, i, dp, edp[i]);
        end
        next_cycle();
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_fetch_wait();
    logic        rdy [6];
    logic [11:0] ess [6];
    logic [13:0] edp [6];
    rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ess = '{12'h040, 12'h040, 12'h040, 12'h0D0, 12'h100, 12'hB81};
    edp = '{DP_F, DP_F, DP_F, DP_F, DP_D, DP_J};
    opcode = 6'b000010;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rdy[i];
      #2;
      tests++;
      if (ss !== ess[i]) begin
        failures++;
        $display("FAIL fetch_wait_c%0d state/strobes: got %h want %h", i, ss, ess[i]);
      end
      tests++;
      if (dp !== edp[i]) begin
        failures++;
        $display("FAIL fetch_wait_c%0d selects: got %h want %h", i, dp, edp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_iexec();
    logic [11:0] ess [4];
    logic [13:0] edp [4];
    ess = '{12'h0D0, 12'h100, 12'h900, 12'hA09};
    edp = '{DP_F, DP_D, DP_ORI, DP_ORI};
    opcode = 6'b001101;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      tests++;
      if (ss !== ess[i]) begin
        failures++;
        $display("FAIL ori_c%0d state/strobes: got %h want %h", i, ss, ess[i]);
      end
      tests++;
      if (dp !== edp[i]) begin
        failures++;
        $display("FAIL ori_c%0d selects: got %h want %h", i, dp, edp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_sw_timeout();
    logic        rdy [18];
    logic        rs  [18];
    logic [11:0] ess [18];
    logic [13:0] edp [18];
    rdy = '{1, 1, 1, 1,  1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0};
    rs  = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0};
    ess = '{12'h0D0, 12'h100, 12'h200, 12'h521,
            12'h0D0, 12'h100, 12'h200, 12'h520, 12'h520, 12'h520, 12'h520, 12'h502,
            12'h0D0, 12'h100, 12'h200, 12'h520, 12'h500, 12'h040};
    edp = '{DP_F, DP_D, DP_MA, DP_MEM,
            DP_F, DP_D, DP_MA, DP_MEM, DP_MEM, DP_MEM, DP_MEM, DP_MEM,
            DP_F, DP_D, DP_MA, DP_MEM, DP_MEM, DP_F};
    opcode = 6'b101011;
    for (int i = 0; i < 18; i++) begin
      mem_ready = rdy[i];
      rst = rs[i];
      #2;
      tests++;
      if (ss !== ess[i]) begin
        failures++;
        $display("FAIL sw_c%0d state/strobes: got %h want %h", i, ss, ess[i]);
      end
      tests++;
      if (dp !== edp[i]) begin
        failures++;
        $display("FAIL sw_c%0d selects: got %h want %h", i, dp, edp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal();
    logic        rdy [6];
    logic [5:0]  op  [6];
    logic [11:0] ess [6];
    logic [13:0] edp [6];
    rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    op  = '{6'h3F, 6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00};
    ess = '{12'h0D0, 12'h105, 12'h040, 12'h0D0, 12'h105, 12'h040};
    edp = '{DP_F, DP_D, DP_F, DP_F, DP_D, DP_F};
    funct = 6'h3F;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rdy[i];
      opcode = op[i];
      #2;
      tests++;
      if (ss !== ess[i]) begin
        failures++;
        $display("FAIL illegal_c%0d state/strobes: got %h want %h", i, ss, ess[i]);
      end
      tests++;
      if (dp !== edp[i]) begin
        failures++;
        $display("FAIL illegal_c%0d selects: got %h want %h", i, dp, edp[i]);
      end
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    opcode = 6'd0;
    funct = 6'd0;
    zero = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_fetch_wait();
    test_iexec();
    test_sw_timeout();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
